// File: rtl/regfile_pkg.sv
// Shared register-file constants and read-controller state encoding.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned ADDR_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Address to one-hot read-enable decoder; address 0 is the hardwired-zero register
// and never gets an enable.
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter int unsigned AddrW   = ADDR_W,
  parameter int unsigned NumRegs = NUM_REGS
) (
  input  logic [AddrW-1:0]   addr_i,
  output logic [NumRegs-1:0] onehot_o
);

  // Decode with zero-suppress for register 0
  always_comb begin
    onehot_o = '0;
    if (addr_i != '0) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_reader.sv
// Read-side controller for the 16x16 register file: accepts a two-source request,
// drives registered one-hot read enables for two cycles, captures the bitlines and
// returns both operands over a valid/ready response.
// Optional feature: define REGFILE_READER_BYPASS_EN to forward a same-cycle array
// write (wr_en/DstReg/DstData) into the captured data instead of the bitline.
module regfile_reader
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   SrcReg1,
  input  logic [ADDR_W-1:0]   SrcReg2,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  input  logic [WIDTH-1:0]    Bitline1,
  input  logic [WIDTH-1:0]    Bitline2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   DstReg,
  input  logic [WIDTH-1:0]    DstData,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    SrcData1,
  output logic [WIDTH-1:0]    SrcData2
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
  logic [NUM_REGS-1:0] en1_q, en1_d, en2_q, en2_d;
  logic [NUM_REGS-1:0] dec1, dec2;
  logic [WIDTH-1:0]    data1_q, data1_d, data2_q, data2_d;
  logic [WIDTH-1:0]    cap1, cap2;

  // Decoders look at the next-state address so the enables can be registered
  onehot_decoder u_dec1 (
    .addr_i   (addr1_d),
    .onehot_o (dec1)
  );

  onehot_decoder u_dec2 (
    .addr_i   (addr2_d),
    .onehot_o (dec2)
  );

  // Next-state, address latch and enable next-value
  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr1_d = SrcReg1;
          addr2_d = SrcReg2;
          state_d = StDrive;
        end
      end
      StDrive:   state_d = StCapture;
      StCapture: state_d = StResp;
      StResp:    if (rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    en1_d = '0;
    en2_d = '0;
    if (state_d == StDrive || state_d == StCapture) begin
      en1_d = dec1;
      en2_d = dec2;
    end
  end

  // Capture source selection: bitline, or forwarded write data when bypass is built in
  always_comb begin
    cap1 = Bitline1;
    cap2 = Bitline2;
`ifdef REGFILE_READER_BYPASS_EN
    if (wr_en && DstReg == addr1_q && addr1_q != '0) cap1 = DstData;
    if (wr_en && DstReg == addr2_q && addr2_q != '0) cap2 = DstData;
`endif
    data1_d = data1_q;
    data2_d = data2_q;
    if (state_q == StCapture) begin
      data1_d = (addr1_q == '0) ? '0 : cap1;
      data2_d = (addr2_q == '0) ? '0 : cap2;
    end
  end

`ifndef REGFILE_READER_BYPASS_EN
  // Write-side inputs are only meaningful with forwarding built in
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, DstReg, DstData};
`endif

  // State, address, enable and data registers; reset drops enables immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr1_q <= '0;
      addr2_q <= '0;
      en1_q   <= '0;
      en2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign ReadEnable1 = en1_q;
  assign ReadEnable2 = en2_q;
  assign SrcData1    = data1_q;
  assign SrcData2    = data2_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a behavioural tri-state register array.
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  SrcReg1, SrcReg2;
  logic [15:0] ReadEnable1, ReadEnable2;
  logic [15:0] Bitline1, Bitline2;
  logic        wr_en;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        rsp_valid, rsp_ready;
  logic [15:0] SrcData1, SrcData2;

  int nchecks = 0;
  int nerrors = 0;

  logic [15:0] mem [16];

  always #5 clk = ~clk;

  regfile_reader dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .SrcReg1     (SrcReg1),
    .SrcReg2     (SrcReg2),
    .ReadEnable1 (ReadEnable1),
    .ReadEnable2 (ReadEnable2),
    .Bitline1    (Bitline1),
    .Bitline2    (Bitline2),
    .wr_en       (wr_en),
    .DstReg      (DstReg),
    .DstData     (DstData),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .SrcData1    (SrcData1),
    .SrcData2    (SrcData2)
  );

  // Array model: a bitline carries the enabled register, Z when nothing is enabled
  always_comb begin
    Bitline1 = 'z;
    Bitline2 = 'z;
    for (int i = 0; i < 16; i++) begin
      if (ReadEnable1[i]) Bitline1 = mem[i];
      if (ReadEnable2[i]) Bitline2 = mem[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and walk it through DRIVE, CAPTURE and RESP, checking each stage
  task automatic run_req(input logic [3:0] s1, input logic [3:0] s2,
                         input logic [15:0] e_en1, input logic [15:0] e_en2,
                         input logic [15:0] e_d1, input logic [15:0] e_d2);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    SrcReg1   = s1;
    SrcReg2   = s2;
    step();
    req_valid = 1'b0;
    SrcReg1   = 4'hx;
    SrcReg2   = 4'hx;
    chk("drive_en1", {16'd0, ReadEnable1}, {16'd0, e_en1});
    chk("drive_en2", {16'd0, ReadEnable2}, {16'd0, e_en2});
    chk("drive_busy", {30'd0, req_ready, rsp_valid}, 32'd0);
    step();
    chk("capt_en1", {16'd0, ReadEnable1}, {16'd0, e_en1});
    chk("capt_en2", {16'd0, ReadEnable2}, {16'd0, e_en2});
    chk("capt_noval", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_en", {ReadEnable1, ReadEnable2}, 32'd0);
    chk("resp_data", {SrcData1, SrcData2}, {e_d1, e_d2});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("back_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  typedef struct {
    logic [3:0]  s1, s2;
    logic [15:0] en1, en2, d1, d2;
  } vec_t;

  vec_t vecs [5];
  logic [15:0] exp_byp;

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0]  = 16'hDEAD;
    mem[1]  = 16'h0101;
    mem[3]  = 16'h00FF;
    mem[4]  = 16'h1111;
    mem[5]  = 16'hBEEF;
    mem[7]  = 16'hA5A5;
    mem[9]  = 16'h1234;
    mem[12] = 16'h0C0C;
    mem[15] = 16'hF00F;

    vecs[0] = '{s1: 4'd5,  s2: 4'd9, en1: 16'h0020, en2: 16'h0200, d1: 16'hBEEF, d2: 16'h1234};
    vecs[1] = '{s1: 4'd0,  s2: 4'd3, en1: 16'h0000, en2: 16'h0008, d1: 16'h0000, d2: 16'h00FF};
    vecs[2] = '{s1: 4'd7,  s2: 4'd7, en1: 16'h0080, en2: 16'h0080, d1: 16'hA5A5, d2: 16'hA5A5};
    vecs[3] = '{s1: 4'd12, s2: 4'd0, en1: 16'h1000, en2: 16'h0000, d1: 16'h0C0C, d2: 16'h0000};
    vecs[4] = '{s1: 4'd15, s2: 4'd1, en1: 16'h8000, en2: 16'h0002, d1: 16'hF00F, d2: 16'h0101};

    rst       = 1'b1;
    req_valid = 1'b0;
    SrcReg1   = 4'd0;
    SrcReg2   = 4'd0;
    wr_en     = 1'b0;
    DstReg    = 4'd0;
    DstData   = 16'h0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_en", {ReadEnable1, ReadEnable2}, 32'd0);
    chk("rst_data", {SrcData1, SrcData2}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_req(vecs[i].s1, vecs[i].s2, vecs[i].en1, vecs[i].en2, vecs[i].d1, vecs[i].d2);
    end

    // Back-pressure: response and data must hold while rsp_ready is low
    req_valid = 1'b1;
    SrcReg1   = 4'd9;
    SrcReg2   = 4'd5;
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      mem[9] = 16'h0000 + 16'(c);
      chk("hold_valid", {30'd0, rsp_valid, req_ready}, 32'd2);
      chk("hold_data", {SrcData1, SrcData2}, 32'h1234BEEF);
      step();
    end
    mem[9] = 16'h1234;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset during CAPTURE: enables drop without a clock, no response follows
    req_valid = 1'b1;
    SrcReg1   = 4'd5;
    SrcReg2   = 4'd9;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_en", {ReadEnable1, ReadEnable2}, 32'h00200200);
    rst = 1'b1;
    #1;
    chk("async_rst_en", {ReadEnable1, ReadEnable2}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_quiet", {30'd0, rsp_valid, req_ready}, 32'd1);
    end
    run_req(4'd7, 4'd3, 16'h0080, 16'h0008, 16'hA5A5, 16'h00FF);

    // Write to the same register during CAPTURE
`ifdef REGFILE_READER_BYPASS_EN
    exp_byp = 16'h2222;
`else
    exp_byp = 16'h1111;
`endif
    req_valid = 1'b1;
    SrcReg1   = 4'd4;
    SrcReg2   = 4'd0;
    step();
    req_valid = 1'b0;
    step();
    wr_en   = 1'b1;
    DstReg  = 4'd4;
    DstData = 16'h2222;
    step();
    wr_en = 1'b0;
    chk("bypass_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bypass_data", {SrcData1, SrcData2}, {exp_byp, 16'h0000});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bypass_idle", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
